lba_cmd_sequencer: RTL and testbench
====================================

Name: lba_cmd_sequencer

Overview:
Converts the write/read start requests and the LBA range from the switch-control stage into a sequence of bounded multi-sector commands for the downstream host-command layer. Splits [begin_LBA, end_LBA] (inclusive) into chunks of at most MAX_CHUNK sectors and issues each with a valid/ready handshake. Waits for each completion and counts progress. Reports done or a coded error, with abort and watchdog-timeout protection.

Parameters:
LBA_W, 48, LBA width
CNT_W, 16, width of per-command sector count
MAX_CHUNK, 256, max sectors per command (1..2^CNT_W-1)
TIMEOUT_CYC, 1000000, max clk cycles from command accept to completion

Ports:
clk  in  1  clock
nRST  in  1  reset; nRST, asynchronous, active-low; clock clk
start_WR  in  1  write request level; acted on at its rising edge
start_RD  in  1  read request level; acted on at its rising edge
begin_LBA  in  LBA_W  first LBA, sampled at start edge
end_LBA  in  LBA_W  last LBA (inclusive), sampled at start edge
abort  in  1  request stop; sticky until serviced
cmd_valid  out  1  command offered
cmd_ready  in  1  downstream accepts command
cmd_write  out  1  1=write, 0=read
cmd_lba  out  LBA_W  command start LBA
cmd_count  out  CNT_W  sectors in command
cmp_valid  in  1  one-cycle completion strobe for accepted command
cmp_err  in  1  completion carries device error (valid with cmp_valid)
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on successful finish
err  out  1  sticky error flag, cleared at next accepted start
err_code  out  3  0 none, 1 range (begin>end), 2 device, 3 timeout, 4 abort
sectors_done  out  LBA_W  sectors completed in the current/last run

Behaviour:
- Reset: state IDLE. cmd_valid=0, cmd_write=0, cmd_lba=0, cmd_count=0, busy=0, done=0, err=0, err_code=0, sectors_done=0, abort flag=0, edge registers=0.
- Edge detect: registered copies of start_WR/start_RD; start = rising edge. Simultaneous rising edges: write wins. Edges arriving outside IDLE are ignored. A new run requires deassert then reassert.
- IDLE: on start, latch the direction, begin_LBA as cur_lba, and end_LBA. Clear err, err_code, sectors_done and the abort flag. Go to CHECK. busy=1 from the next cycle.
- CHECK (1 cycle):
  - abort flag set -> ERR code 4.
  - begin>end -> ERR code 1.
  - Otherwise remain = end-cur+1, computed 49-bit so that begin=0, end=2^48-1 does not wrap. chunk = min(remain, MAX_CHUNK).
  - Load cmd_lba=cur_lba, cmd_count=chunk, cmd_write=direction. Go to ISSUE.
- ISSUE: cmd_valid=1. Once asserted, cmd_valid and the payload stay stable until cmd_ready=1, even if abort arrives. On valid&ready: drop cmd_valid next cycle, clear the watchdog, go to WAIT_CMP.
  - Latency: start edge sampled at cycle N -> CHECK at N+1 -> cmd_valid=1 at N+2.
- WAIT_CMP: watchdog counts every cycle.
  - cmp_valid & cmp_err -> ERR code 2.
  - cmp_valid & !cmp_err -> sectors_done += cmd_count; go to NEXT.
  - Watchdog reaches TIMEOUT_CYC-1 with no completion -> ERR code 3.
  - cmp_valid on the same cycle as the timeout: the completion wins.
- NEXT (1 cycle):
  - If cmd_lba+cmd_count-1 == end (49-bit compare) -> DONE.
  - Else cur_lba += cmd_count; go to CHECK.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- ERR: set err=1 and latch err_code; busy=0; go to IDLE. err and err_code hold until the next start.
- abort: any cycle outside IDLE sets the sticky flag. It takes effect only at CHECK, so an outstanding command always completes first. A device error or timeout seen while the flag is set reports that code, not 4. abort in IDLE is ignored.
- cmp_valid outside WAIT_CMP is ignored.
- Reset mid-run: everything returns to reset values immediately. No command is re-issued.

Decomposition:
- Shared package ssd_ctrl_pkg holds:
  - LBA_W default
  - state enum (IDLE, CHECK, ISSUE, WAIT_CMP, NEXT, DONE, ERR)
  - err_code constants (ERR_NONE, ERR_RANGE, ERR_DEV, ERR_TIMEOUT, ERR_ABORT)
- One natural sub-module: cmd_watchdog. It is a clear/enable counter with a terminal-count output, parameterised by TIMEOUT_CYC.

Test Plan:
- Write, begin=100, end=699, MAX_CHUNK=256, cmd_ready=1, each completion 5 cycles after accept -> commands (100,256), (356,256), (612,88), all cmd_write=1; then done pulse, sectors_done=600, err=0.
- start_WR and start_RD rise in the same cycle, begin=end=7 -> exactly one command (7,1) with cmd_write=1; done after its completion; start_RD then held high produces no second run.
- Read, begin=50, end=49 -> no cmd_valid; err=1, err_code=1 two cycles after the edge; busy returns to 0.
- cmd_ready held low 20 cycles with abort pulsed mid-wait -> cmd_valid and payload stable until ready; after the completion, ERR code 4 with no further commands; sectors_done=first chunk.
- TIMEOUT_CYC=16, no completion after accept -> err_code=3 on the 16th cycle after accept. Repeat with cmp_valid on that same cycle -> no error, run continues.
- Second command completes with cmp_err=1 -> err_code=2, sectors_done=256. Then nRST asserted mid-ISSUE on a later run -> cmd_valid=0 and all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ssd_ctrl_pkg.sv
// Shared types and constants for the SSD controller command path.
package ssd_ctrl_pkg;

  localparam int unsigned LbaWDefault = 48;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StWaitCmp,
    StNext,
    StDone,
    StErr
  } seq_state_e;

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrRange   = 3'd1;
  localparam logic [2:0] ErrDev     = 3'd2;
  localparam logic [2:0] ErrTimeout = 3'd3;
  localparam logic [2:0] ErrAbort   = 3'd4;

endpackage

// File: rtl/cmd_watchdog.sv
// Clear/enable cycle counter; expired_o flags the cycle on which the count sits at TIMEOUT_CYC-1.
module cmd_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lba_cmd_sequencer.sv
// Splits an inclusive LBA range into bounded multi-sector commands, tracks completions,
// and reports done or a coded error (range, device, timeout, abort).
module lba_cmd_sequencer
  import ssd_ctrl_pkg::*;
#(
  parameter int unsigned LBA_W       = LbaWDefault,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_CHUNK   = 256,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start_WR,
  input  logic             start_RD,
  input  logic [LBA_W-1:0] begin_LBA,
  input  logic [LBA_W-1:0] end_LBA,
  input  logic             abort,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_write,
  output logic [LBA_W-1:0] cmd_lba,
  output logic [CNT_W-1:0] cmd_count,
  input  logic             cmp_valid,
  input  logic             cmp_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [LBA_W-1:0] sectors_done
);

  seq_state_e       state_q, state_d;
  logic             start_wr_q, start_rd_q;
  logic             dir_q, dir_d;
  logic [LBA_W-1:0] cur_lba_q, cur_lba_d;
  logic [LBA_W-1:0] end_lba_q, end_lba_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [LBA_W-1:0] sectors_done_q, sectors_done_d;
  logic [LBA_W-1:0] cmd_lba_q, cmd_lba_d;
  logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
  logic             cmd_write_q, cmd_write_d;

  logic             wr_edge, rd_edge;
  logic             wd_expired;
  logic [LBA_W:0]   remain;
  logic [CNT_W-1:0] chunk;
  logic [LBA_W:0]   last_lba;

  assign wr_edge = start_WR & ~start_wr_q;
  assign rd_edge = start_RD & ~start_rd_q;

  // One extra bit so a full 0..2^LBA_W-1 range does not wrap to zero.
  assign remain   = {1'b0, end_lba_q} - {1'b0, cur_lba_q} + (LBA_W+1)'(1);
  assign chunk    = (remain > (LBA_W+1)'(MAX_CHUNK)) ? CNT_W'(MAX_CHUNK) : remain[CNT_W-1:0];
  assign last_lba = {1'b0, cmd_lba_q} + (LBA_W+1)'(cmd_count_q) - (LBA_W+1)'(1);

  cmd_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .nRST     (nRST),
    .clr_i    (state_q == StIssue && cmd_ready),
    .en_i     (state_q == StWaitCmp),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    cur_lba_d      = cur_lba_q;
    end_lba_d      = end_lba_q;
    abort_d        = abort_q;
    err_d          = err_q;
    err_code_d     = err_code_q;
    sectors_done_d = sectors_done_q;
    cmd_lba_d      = cmd_lba_q;
    cmd_count_d    = cmd_count_q;
    cmd_write_d    = cmd_write_q;

    if (state_q != StIdle && abort) begin
      abort_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (wr_edge || rd_edge) begin
          dir_d          = wr_edge;
          cur_lba_d      = begin_LBA;
          end_lba_d      = end_LBA;
          err_d          = 1'b0;
          err_code_d     = ErrNone;
          sectors_done_d = '0;
          abort_d        = 1'b0;
          state_d        = StCheck;
        end
      end
      StCheck: begin
        if (abort_q) begin
          err_d      = 1'b1;
          err_code_d = ErrAbort;
          state_d    = StErr;
        end else if (cur_lba_q > end_lba_q) begin
          err_d      = 1'b1;
          err_code_d = ErrRange;
          state_d    = StErr;
        end else begin
          cmd_lba_d   = cur_lba_q;
          cmd_count_d = chunk;
          cmd_write_d = dir_q;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready) begin
          state_d = StWaitCmp;
        end
      end
      StWaitCmp: begin
        // A completion arriving on the expiry cycle takes priority over the timeout.
        if (cmp_valid) begin
          if (cmp_err) begin
            err_d      = 1'b1;
            err_code_d = ErrDev;
            state_d    = StErr;
          end else begin
            sectors_done_d = sectors_done_q + LBA_W'(cmd_count_q);
            state_d        = StNext;
          end
        end else if (wd_expired) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
          state_d    = StErr;
        end
      end
      StNext: begin
        if (last_lba == {1'b0, end_lba_q}) begin
          state_d = StDone;
        end else begin
          cur_lba_d = cur_lba_q + LBA_W'(cmd_count_q);
          state_d   = StCheck;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q        <= StIdle;
      start_wr_q     <= 1'b0;
      start_rd_q     <= 1'b0;
      dir_q          <= 1'b0;
      cur_lba_q      <= '0;
      end_lba_q      <= '0;
      abort_q        <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= ErrNone;
      sectors_done_q <= '0;
      cmd_lba_q      <= '0;
      cmd_count_q    <= '0;
      cmd_write_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_wr_q     <= start_WR;
      start_rd_q     <= start_RD;
      dir_q          <= dir_d;
      cur_lba_q      <= cur_lba_d;
      end_lba_q      <= end_lba_d;
      abort_q        <= abort_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      sectors_done_q <= sectors_done_d;
      cmd_lba_q      <= cmd_lba_d;
      cmd_count_q    <= cmd_count_d;
      cmd_write_q    <= cmd_write_d;
    end
  end

  assign cmd_valid    = (state_q == StIssue);
  assign busy         = (state_q == StCheck) || (state_q == StIssue) ||
                        (state_q == StWaitCmp) || (state_q == StNext);
  assign done         = (state_q == StDone);
  assign cmd_write    = cmd_write_q;
  assign cmd_lba      = cmd_lba_q;
  assign cmd_count    = cmd_count_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign sectors_done = sectors_done_q;

endmodule

// File: tb/tb_lba_cmd_sequencer.sv
// Scoreboard bench: a range-splitting model queues expected commands and run outcomes,
// a monitor pops and compares them as the sequencer presents them.
module tb_lba_cmd_sequencer;

  localparam int unsigned LBA_W       = 48;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned MAX_CHUNK   = 256;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             nRST;
  logic             start_WR, start_RD;
  logic [LBA_W-1:0] begin_LBA, end_LBA;
  logic             abort;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [LBA_W-1:0] cmd_lba;
  logic [CNT_W-1:0] cmd_count;
  logic             cmp_valid, cmp_err;
  logic             busy, done, err;
  logic [2:0]       err_code;
  logic [LBA_W-1:0] sectors_done;

  typedef struct packed {
    logic [63:0] lba;
    logic [63:0] cnt;
    logic        wr;
  } cmd_t;

  typedef struct {
    int          code;
    logic [63:0] sect;
  } end_t;

  cmd_t exp_cmd_q[$];
  end_t exp_end_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int ends_seen = 0;
  int cmd_idx = 0;
  int err_idx = -1;
  int none_idx = -1;
  int resp_delay = 5;
  bit rnd_delay = 1'b0;
  bit rnd_ready = 1'b0;

  lba_cmd_sequencer #(
    .LBA_W      (LBA_W),
    .CNT_W      (CNT_W),
    .MAX_CHUNK  (MAX_CHUNK),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .start_WR    (start_WR),
    .start_RD    (start_RD),
    .begin_LBA   (begin_LBA),
    .end_LBA     (end_LBA),
    .abort       (abort),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_lba     (cmd_lba),
    .cmd_count   (cmd_count),
    .cmp_valid   (cmp_valid),
    .cmp_err     (cmp_err),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .sectors_done(sectors_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the range in MAX_CHUNK steps; lim truncates the list for error runs.
  task automatic model(bit wr, logic [63:0] b, logic [63:0] e, int code, int lim);
    logic [63:0] lba, cnt, sum, last;
    end_t        rec;
    int          n;
    lba  = b;
    sum  = 0;
    last = 0;
    n    = 0;
    if (code != 1) begin
      while (lba <= e && n < lim) begin
        cnt = (e - lba + 1 > 64'(MAX_CHUNK)) ? 64'(MAX_CHUNK) : e - lba + 1;
        exp_cmd_q.push_back('{lba, cnt, wr});
        sum  += cnt;
        last  = cnt;
        lba  += cnt;
        n++;
      end
    end
    rec.code = code;
    if (code == 0 || code == 4) rec.sect = sum;
    else if (code == 1) rec.sect = 0;
    else rec.sect = sum - last;
    exp_end_q.push_back(rec);
    cmd_idx = 0;
  endtask

  task automatic raise(bit wr, bit rd, logic [63:0] b, logic [63:0] e);
    @(posedge clk);
    #1;
    begin_LBA = b[LBA_W-1:0];
    end_LBA   = e[LBA_W-1:0];
    start_WR  = wr;
    start_RD  = rd;
  endtask

  task automatic lower();
    @(posedge clk);
    #1;
    start_WR = 1'b0;
    start_RD = 1'b0;
  endtask

  task automatic wait_end(string name, int budget);
    int s, k;
    s = ends_seen;
    k = 0;
    while (ends_seen == s && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk({name, "_ended"}, 64'(ends_seen != s), 64'd1);
  endtask

  task automatic run(string name, bit wr, bit rd, logic [63:0] b, logic [63:0] e, int code,
                     int lim);
    model(wr, b, e, code, lim);
    raise(wr, rd, b, e);
    wait_end(name, 20000);
    lower();
    repeat (3) @(posedge clk);
    chk({name, "_drained"}, 64'(exp_cmd_q.size()), 64'd0);
  endtask

  // Completion responder: acts on accepts seen at the falling edge before the accepting edge.
  initial begin
    int idx, d;
    cmp_valid = 1'b0;
    cmp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (nRST && cmd_valid && cmd_ready) begin
        idx = cmd_idx;
        cmd_idx++;
        d = rnd_delay ? int'($urandom_range(1, 8)) : resp_delay;
        @(posedge clk);
        if (idx != none_idx) begin
          repeat (d - 1) @(posedge clk);
          #1;
          cmp_valid = 1'b1;
          cmp_err   = (idx == err_idx);
          @(posedge clk);
          #1;
          cmp_valid = 1'b0;
          cmp_err   = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) cmd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  initial begin
    bit   err_prev;
    cmd_t c;
    end_t r;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!nRST) begin
        err_prev = 1'b0;
      end else begin
        if (cmd_valid) begin
          if (exp_cmd_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_cmd: got lba %0h count %0h, expected none", cmd_lba,
                     cmd_count);
          end else begin
            c = exp_cmd_q[0];
            chk("cmd_lba", 64'(cmd_lba), c.lba);
            chk("cmd_count", 64'(cmd_count), c.cnt);
            chk("cmd_write", 64'(cmd_write), 64'(c.wr));
            if (cmd_ready) void'(exp_cmd_q.pop_front());
          end
        end
        if (done || (err && !err_prev)) begin
          if (exp_end_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_end: got done %0d err %0d, expected none", done, err);
          end else begin
            r = exp_end_q.pop_front();
            chk("end_kind_done", 64'(done), 64'(r.code == 0));
            chk("end_code", done ? 64'd0 : 64'(err_code), 64'(r.code));
            chk("end_sectors", 64'(sectors_done), r.sect);
          end
          ends_seen++;
        end
        err_prev = err;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    nRST      = 1'b0;
    start_WR  = 1'b0;
    start_RD  = 1'b0;
    begin_LBA = '0;
    end_LBA   = '0;
    abort     = 1'b0;
    cmd_ready = 1'b1;
    #23;
    chk("rst_cmd_valid", 64'(cmd_valid), 0);
    chk("rst_cmd_write", 64'(cmd_write), 0);
    chk("rst_cmd_lba", 64'(cmd_lba), 0);
    chk("rst_cmd_count", 64'(cmd_count), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_err_code", 64'(err_code), 0);
    chk("rst_sectors", 64'(sectors_done), 0);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    repeat (2) @(posedge clk);

    // Write split into 256/256/88
    run("wr_split", 1'b1, 1'b0, 64'd100, 64'd699, 0, 1000);
    chk("wr_split_err", 64'(err), 0);
    chk("wr_split_sect", 64'(sectors_done), 64'd600);

    // Simultaneous edges: write wins, held read level must not retrigger
    model(1'b1, 64'd7, 64'd7, 0, 1000);
    raise(1'b1, 1'b1, 64'd7, 64'd7);
    wait_end("both", 2000);
    @(posedge clk);
    #1;
    start_WR = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("both_no_rerun", 64'(busy), 0);
    end
    lower();
    chk("both_drained", 64'(exp_cmd_q.size()), 0);

    // Range error: err visible two cycles after the edge cycle
    model(1'b0, 64'd50, 64'd49, 1, 0);
    raise(1'b0, 1'b1, 64'd50, 64'd49);
    @(posedge clk);
    #1;
    chk("range_busy_n1", 64'(busy), 1);
    chk("range_err_n1", 64'(err), 0);
    @(posedge clk);
    #1;
    chk("range_err_n2", 64'(err), 1);
    chk("range_code_n2", 64'(err_code), 1);
    chk("range_busy_n2", 64'(busy), 0);
    lower();
    repeat (2) @(posedge clk);

    // Abort during a stalled issue on the full 48-bit range
    model(1'b1, 64'd0, 64'hFFFF_FFFF_FFFF, 4, 1);
    cmd_ready = 1'b0;
    raise(1'b1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    chk("abort_valid_n1", 64'(cmd_valid), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("abort_valid_held", 64'(cmd_valid), 1);
      abort = (i == 10);
      @(posedge clk);
      #1;
    end
    abort     = 1'b0;
    cmd_ready = 1'b1;
    wait_end("abort", 2000);
    chk("abort_code", 64'(err_code), 4);
    lower();
    repeat (3) @(posedge clk);
    chk("abort_drained", 64'(exp_cmd_q.size()), 0);

    // Timeout on the 16th cycle after accept
    none_idx = 0;
    model(1'b1, 64'd1000, 64'd1299, 3, 1);
    raise(1'b1, 1'b0, 64'd1000, 64'd1299);
    repeat (18) @(posedge clk);
    #1;
    chk("tmo_err_early", 64'(err), 0);
    chk("tmo_busy_early", 64'(busy), 1);
    @(posedge clk);
    #1;
    chk("tmo_err", 64'(err), 1);
    chk("tmo_code", 64'(err_code), 3);
    lower();
    repeat (3) @(posedge clk);
    chk("tmo_drained", 64'(exp_cmd_q.size()), 0);
    none_idx = -1;

    // Completion on the expiry cycle wins
    resp_delay = 16;
    run("tmo_race", 1'b0, 1'b1, 64'd1000, 64'd1299, 0, 1000);
    resp_delay = 5;

    // Device error on second command
    err_idx = 1;
    run("dev_err", 1'b1, 1'b0, 64'd0, 64'd599, 2, 2);
    err_idx = -1;

    // Asynchronous reset while a command is offered
    model(1'b0, 64'd5000, 64'd5999, 0, 1);
    cmd_ready = 1'b0;
    raise(1'b0, 1'b1, 64'd5000, 64'd5999);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_valid_before", 64'(cmd_valid), 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(cmd_valid), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_lba", 64'(cmd_lba), 0);
    chk("rst_mid_count", 64'(cmd_count), 0);
    chk("rst_mid_err", 64'(err), 0);
    chk("rst_mid_sect", 64'(sectors_done), 0);
    start_RD  = 1'b0;
    cmd_ready = 1'b1;
    exp_cmd_q.delete();
    exp_end_q.delete();
    @(posedge clk);
    #1;
    nRST = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("rst_no_reissue", 64'(cmd_valid), 0);
    end

    // Randomized ranges, directions, ready and completion latency
    rnd_delay = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [63:0] b, len;
      bit          wr;
      len = 64'($urandom_range(1, 900));
      b   = (i == 0) ? (64'h1_0000_0000_0000 - len) : 64'($urandom);
      wr  = 1'($urandom_range(0, 1));
      run("rand", wr, !wr, b, b + len - 1, 0, 1000);
    end
    rnd_ready = 1'b0;
    rnd_delay = 1'b0;
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    chk("ends_drained", 64'(exp_end_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
